// File: rtl/tx_burst_arbiter.sv
// tx_burst_arbiter: round-robin arbiter that lets each requester write a whole burst
// into the shared TX FIFO before the next requester gets the port.
module tx_burst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*LEN_W-1:0] req_len_i,
  input  logic [NUM_REQ*8-1:0]     req_data_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  input  logic                     tx_fifo_full_i,
  output logic                     tx_fifo_wen_o,
  output logic [7:0]               tx_fifo_wdata_o,
  output logic                     busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_d;
  logic [NUM_REQ-1:0] grant_d, done_d;
  logic busy_d, found;
  logic [IW-1:0] last_grant, last_d, gidx, gidx_d, win, cand;
  logic [LEN_W:0] cnt, cnt_d;
  logic [LEN_W-1:0] win_len;
  assign req_ready_o = grant_o & {NUM_REQ{~tx_fifo_full_i}};
  assign tx_fifo_wen_o = |(req_ready_o & req_valid_i);
  assign tx_fifo_wdata_o = req_data_i[gidx*8 +: 8];
  assign win_len = req_len_i[win*LEN_W +: LEN_W];
  // first pending requester after the last one served, wrapping around
  always_comb begin
    win = '0;
    cand = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        win = cand;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state;
    grant_d = grant_o;
    done_d = '0;
    busy_d = busy_o;
    last_d = last_grant;
    cnt_d = cnt;
    gidx_d = gidx;
    if (state == IDLE) begin
      if (found) begin
        state_d = XFER;
        grant_d = NUM_REQ'(1) << win;
        busy_d = 1'b1;
        gidx_d = win;
        cnt_d = {win_len == '0, win_len};
      end
    end else if (tx_fifo_wen_o) begin
      cnt_d = cnt - 1'b1;
      if (cnt == (LEN_W+1)'(1)) begin
        state_d = IDLE;
        grant_d = '0;
        busy_d = 1'b0;
        done_d = grant_o;
        last_d = gidx;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      grant_o <= '0;
      done_o <= '0;
      busy_o <= 1'b0;
      last_grant <= IW'(NUM_REQ-1);
      cnt <= '0;
      gidx <= '0;
    end else begin
      state <= state_d;
      grant_o <= grant_d;
      done_o <= done_d;
      busy_o <= busy_d;
      last_grant <= last_d;
      cnt <= cnt_d;
      gidx <= gidx_d;
    end
  end
endmodule

// File: doc/tx_burst_arbiter.md
Name: tx_burst_arbiter

Overview:
- Shares the single UART TX FIFO write port among NUM_REQ byte-stream requesters.
- Each requester submits a burst of a committed length. Bursts are granted round-robin and written atomically, so bytes from different requesters never interleave on the serial line.
- Sits between client logic and the TX FIFO that feeds the transmit engine. Write-side flow control comes from the FIFO full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LEN_W, 8, width of each burst length field. A length of 0 encodes 2^LEN_W bytes.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  reset, synchronous, active-high.
- req_i  in  NUM_REQ  per-requester burst request, level.
- req_len_i  in  NUM_REQ*LEN_W  per-requester burst length. Slice k is [k*LEN_W +: LEN_W].
- req_data_i  in  NUM_REQ*8  per-requester data byte. Slice k is [k*8 +: 8].
- req_valid_i  in  NUM_REQ  per-requester data valid.
- req_ready_o  out  NUM_REQ  per-requester data ready, combinational.
- grant_o  out  NUM_REQ  one-hot burst grant, registered.
- done_o  out  NUM_REQ  one-cycle burst-complete pulse, registered.
- tx_fifo_full_i  in  1  TX FIFO full.
- tx_fifo_wen_o  out  1  TX FIFO write enable, combinational.
- tx_fifo_wdata_o  out  8  TX FIFO write data, combinational.
- busy_o  out  1  a burst is granted, registered.

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values:
  - grant_o=0, done_o=0, busy_o=0.
  - Internal last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
  - Byte counter = 0, state = IDLE.
  - req_ready_o=0 and tx_fifo_wen_o=0, since both derive from grant_o.
- FSM has two states, IDLE and XFER.
- IDLE:
  - If any req_i bit is set, select the first set bit scanning upward from last_grant+1, wrapping modulo NUM_REQ.
  - Next cycle: grant_o = one-hot of the winner, busy_o=1, state=XFER.
  - Latch the byte count from the winner's req_len_i; value 0 loads 2^LEN_W. The counter is LEN_W+1 bits wide.
  - Latency: request sampled at edge N gives grant_o high after edge N+1.
- XFER, granted index g:
  - Ready and write: req_ready_o[g] = ~tx_fifo_full_i; all other ready bits are 0. tx_fifo_wen_o = req_valid_i[g] & req_ready_o[g]. tx_fifo_wdata_o = slice g of req_data_i.
  - Handshakes: each handshake cycle decrements the counter by 1. Valid gaps are allowed, and the counter holds during them.
  - When the handshake occurs with counter==1, the next cycle: grant_o=0, busy_o=0, done_o[g]=1 for exactly one cycle, last_grant=g, state=IDLE.
  - Throughput: 1 byte/cycle maximum.
  - Inter-burst gap: at least one cycle between bursts, because IDLE arbitrates on the cycle done_o is high.
- tx_fifo_full_i: while high, no write occurs and no count decrement; ready drops combinationally.
- req_i during a burst:
  - The length is committed at grant. req_i deassertion mid-burst is ignored and the burst still completes.
  - req_len_i changes after grant are ignored.
  - The granted requester may be re-granted only after another pending requester has been served; round-robin guarantees this.
- Simultaneous requests: resolved purely by round-robin order from last_grant+1. No starvation; worst-case wait is NUM_REQ-1 bursts.
- Data and valid from non-granted requesters are ignored. Their ready is always 0.
- Reset mid-burst: returns to reset values on the next edge. The partial burst is abandoned, no done_o is pulsed, and bytes already written stay in the FIFO.
- grant_o is always zero or one-hot. done_o is never set while grant_o is nonzero.

Test Plan:
- Single burst: req_i=0001, len=3, data A1,A2,A3 valid back-to-back, FIFO not full -> grant_o=0001 one cycle after request; FIFO writes A1,A2,A3 on consecutive cycles; done_o=0001 for one cycle; grant_o=0.
- Round-robin: req_i=1011 held, every len=2 -> grant order 0,1,3,0,1,3; no byte interleaving; each done_o pulse matches the preceding grant.
- Backpressure: requester 2 granted, len=4; tx_fifo_full_i high for 3 cycles after the 2nd byte -> req_ready_o[2]=0 and wen=0 during those cycles; bytes 3-4 resume; exactly 4 writes; done after the 4th.
- Length zero: len=0, valid always high, FIFO never full -> exactly 256 writes with payload in order, then done_o.
- Valid gaps and req drop: len=3, valid pattern 1,0,0,1,0,1, req_i dropped after grant -> 3 writes; done_o pulses after the 3rd; no re-grant to that requester.
- Reset mid-burst: reset_i asserted after 2 of 5 bytes -> next cycle grant_o=0, busy_o=0, no done_o; the next request from requester 0 is granted first.
